score_display_converter: RTL

//  Downstream consumer of the 8-bit running score counter. Converts the binary

---
 rtl/starflux_pkg.sv | 21 ++
 rtl/bcd_to_7seg.sv | 19 +
 rtl/score_display_converter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/starflux_pkg.sv
// Shared definitions for the score display path: score width default,
// active-low seven-segment patterns and the converter FSM encoding.
package starflux_pkg;

  localparam int SCORE_W_DEF = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a} patterns for the DE2 HEX displays.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank
// override. Non-decimal codes are shown blank.
module bcd_to_7seg
  import starflux_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: assigning a default before any condition keeps always_comb free of inferred latches.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_DIGIT[bcd];
    end
  end

endmodule

// File: rtl/score_display_converter.sv
// Converts the running binary score to BCD one bit per cycle (double dabble),
// drives the HEX digits from the committed result and tracks the session best.
module score_display_converter
  import starflux_pkg::*;
#(
  parameter int SCORE_W  = SCORE_W_DEF,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  best_clear,
  output logic [7*DIGITS-1:0]   hex,
  output logic [SCORE_W-1:0]    best_score,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

  function automatic logic [7*DIGITS-1:0] reset_hex();
    logic [7*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = ((i == 0) || !BLANK_LZ) ? SEG_DIGIT[0] : SEG_BLANK;
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RESET = reset_hex();

  // Add 3 to every nibble of 5 or more so the following shift carries into the next digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  conv_state_e          state_q,   state_d;
  logic [SCORE_W-1:0]   bin_q,     bin_d;
  logic [BCD_W-1:0]     bcd_q,     bcd_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [SCORE_W-1:0]   latched_q, latched_d;
  logic [SCORE_W-1:0]   shown_q,   shown_d;
  logic [SCORE_W-1:0]   best_q,    best_d;
  logic [7*DIGITS-1:0]  hex_q,     hex_d;
  logic                 busy_q,    busy_d;

  logic [DIGITS-1:0]    blank_w;
  logic [7*DIGITS-1:0]  seg_w;
  logic                 lead_zero;

  // A digit is blanked only when it and every digit above it are zero; units always show.
  always_comb begin
    blank_w   = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead_zero  = lead_zero && (bcd_q[4*i +: 4] == 4'd0);
      blank_w[i] = BLANK_LZ && lead_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_7seg u_dec (
      .bcd   (bcd_q[4*g +: 4]),
      .blank (blank_w[g]),
      .seg   (seg_w[7*g +: 7])
    );
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    latched_d = latched_q;
    shown_d   = shown_q;
    best_d    = best_q;
    hex_d     = hex_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (score != shown_q) begin
          latched_d = score;
          bin_d     = score;
          bcd_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        hex_d   = seg_w;
        shown_d = latched_q;
        if (latched_q > best_q) best_d = latched_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear on the commit cycle overrides the best-score update.
    if (best_clear) best_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      latched_q <= '0;
      shown_q   <= '0;
      best_q    <= '0;
      hex_q     <= HEX_RESET;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      shown_q   <= shown_d;
      best_q    <= best_d;
      hex_q     <= hex_d;
      busy_q    <= busy_d;
    end
  end

  assign hex        = hex_q;
  assign best_score = best_q;
  assign busy       = busy_q;

endmodule
